// File: rtl/fib_pkg.sv
// Shared types and defaults for the explicit-stack Fibonacci controller.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package fib_pkg;

    localparam int OP_W            = 3;
    localparam int STACK_DEPTH_DEF = 8;
    localparam int ACC_W_DEF       = 8;

    typedef logic [OP_W-1:0] op_t;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_POP  = 3'd1,
        ST_DEC1 = 3'd2,
        ST_DEC2 = 3'd3,
        ST_DONE = 3'd4
    } state_t;

endpackage

// File: rtl/fib_stack.sv
// LIFO of operands for the recursion tree; dout is the live top-of-stack entry.
// Latency: push/pop take effect at the next clock edge, dout is combinational.
// Backpressure: push when full and pop when empty are ignored; the caller flags them.
//
// Ports: clk/rst (sync active-high), push/din, pop, dout (top entry, 0 when empty),
//        full, empty.
module fib_stack
    import fib_pkg::*;
#(
    parameter int DEPTH = STACK_DEPTH_DEF
) (
    input  logic clk,
    input  logic rst,
    input  logic push,
    input  logic pop,
    input  op_t  din,
    output op_t  dout,
    output logic full,
    output logic empty
);

    localparam int SP_W = $clog2(DEPTH + 1);
    localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    op_t             mem_q [DEPTH];
    logic [SP_W-1:0] sp_q;
    logic [AW-1:0]   wr_idx;
    logic [AW-1:0]   rd_idx;

    assign full   = (sp_q == SP_W'(DEPTH));
    assign empty  = (sp_q == '0);
    assign wr_idx = sp_q[AW-1:0];
    // When full the write index wraps to 0, so the top entry is still idx-1 modulo depth.
    assign rd_idx = wr_idx - AW'(1);
    assign dout   = empty ? '0 : mem_q[rd_idx];

    always_ff @(posedge clk) begin
        if (rst) begin
            sp_q <= '0;
        end else if (push && !full) begin
            mem_q[wr_idx] <= din;
            sp_q          <= sp_q + SP_W'(1);
        end else if (pop && !empty) begin
            sp_q <= sp_q - SP_W'(1);
        end
    end

endmodule

// File: rtl/fib_seq_ctrl.sv
// Computes fib(n) by walking the recursion tree with an explicit stack, summing the leaves.
// Latency: 2*(2*fib(n+1)-1) cycles from the accepting edge to the done pulse.
// Backpressure: start is only sampled in IDLE; starts while busy are dropped.
//
// Ports: clk, rst (sync active-high), start/n (request), sub_a/sub_b/sub_s (external
//        3-bit subtractor), busy, done (1-cycle pulse), result, err (sticky stack fault).
module fib_seq_ctrl
    import fib_pkg::*;
#(
    parameter int STACK_DEPTH = STACK_DEPTH_DEF,
    parameter int ACC_W       = ACC_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [OP_W-1:0]  n,
    output logic [OP_W-1:0]  sub_a,
    output logic [OP_W-1:0]  sub_b,
    input  logic [OP_W-1:0]  sub_s,
    output logic             busy,
    output logic             done,
    output logic [ACC_W-1:0] result,
    output logic             err
);

    state_t           state_q, state_d;
    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] result_q, result_d;
    op_t              k_q, k_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic stk_push, stk_pop, stk_full, stk_empty;
    op_t  stk_din, stk_dout;

    fib_stack #(
        .DEPTH (STACK_DEPTH)
    ) u_stack (
        .clk   (clk),
        .rst   (rst),
        .push  (stk_push),
        .pop   (stk_pop),
        .din   (stk_din),
        .dout  (stk_dout),
        .full  (stk_full),
        .empty (stk_empty)
    );

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        result_d = result_q;
        k_d      = k_q;
        done_d   = 1'b0;
        err_d    = err_q;
        stk_push = 1'b0;
        stk_pop  = 1'b0;
        stk_din  = sub_s;
        sub_a    = '0;
        sub_b    = '0;

        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    stk_push = 1'b1;
                    stk_din  = n;
                    acc_d    = '0;
                    err_d    = 1'b0;
                    state_d  = ST_POP;
                end
            end
            ST_POP: begin
                if (stk_empty) begin
                    // done and result are registered on DONE entry so they appear together.
                    done_d   = 1'b1;
                    result_d = acc_q;
                    state_d  = ST_DONE;
                end else begin
                    stk_pop = 1'b1;
                    if (stk_dout < op_t'(2)) begin
                        // Leaf: fib(0)=0, fib(1)=1, so the leaf value is its contribution.
                        acc_d = acc_q + ACC_W'(stk_dout);
                    end else begin
                        k_d     = stk_dout;
                        state_d = ST_DEC1;
                    end
                end
            end
            ST_DEC1: begin
                sub_a    = k_q;
                sub_b    = op_t'(1);
                stk_push = 1'b1;
                state_d  = ST_DEC2;
            end
            ST_DEC2: begin
                sub_a    = k_q;
                sub_b    = op_t'(2);
                stk_push = 1'b1;
                state_d  = ST_POP;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Overflowing pushes are dropped by the stack; the run still drains to DONE.
        if ((stk_push && stk_full) || (stk_pop && stk_empty)) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            result_q <= '0;
            k_q      <= '0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            k_q      <= k_d;
            done_q   <= done_d;
            err_q    <= err_d;
        end
    end

    assign busy   = (state_q != ST_IDLE);
    assign done   = done_q;
    assign result = result_q;
    assign err    = err_q;

endmodule

// File: tb/tb_fib_seq_ctrl.sv
module tb_fib_seq_ctrl;
    import fib_pkg::*;

    logic       clk = 1'b0;
    logic       rst, start, start2;
    logic [2:0] n, n2;
    logic [2:0] sub_a, sub_b, sub_s, sub_a2, sub_b2, sub_s2;
    logic       busy, done, err, busy2, done2, err2;
    logic [7:0] result, result2;

    always #5 clk = ~clk;

    // External subtractors.
    assign sub_s  = sub_a - sub_b;
    assign sub_s2 = sub_a2 - sub_b2;

    fib_seq_ctrl #(.STACK_DEPTH(8), .ACC_W(8)) u_dut (
        .clk(clk), .rst(rst), .start(start), .n(n),
        .sub_a(sub_a), .sub_b(sub_b), .sub_s(sub_s),
        .busy(busy), .done(done), .result(result), .err(err)
    );

    fib_seq_ctrl #(.STACK_DEPTH(2), .ACC_W(8)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2), .n(n2),
        .sub_a(sub_a2), .sub_b(sub_b2), .sub_s(sub_s2),
        .busy(busy2), .done(done2), .result(result2), .err(err2)
    );

    int checks   = 0;
    int failures = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: plain arithmetic on the recursion tree.
    function automatic int fib_ref(input int k);
        int a = 0;
        int b = 1;
        int t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic int lat_ref(input int k);
        return 2 * (2 * fib_ref(k + 1) - 1);
    endfunction

    function automatic int max_depth_ref(input int k);
        int q[$];
        int m = 1;
        int v;
        q.push_back(k);
        while (q.size() > 0) begin
            v = q.pop_back();
            if (v >= 2) begin
                q.push_back(v - 1);
                q.push_back(v - 2);
                if (q.size() > m) m = q.size();
            end
        end
        return m;
    endfunction

    typedef struct {
        logic [2:0] n;
        int         exp_res;
        int         exp_lat;
    } vec_t;

    vec_t       tbl[8];
    logic [2:0] sa_log[4];
    logic [2:0] sb_log[4];
    int         lat, ndone, bcnt;

    task automatic check_all_zero(input string tag);
        check({tag, " busy"},   32'(busy),   32'd0);
        check({tag, " done"},   32'(done),   32'd0);
        check({tag, " result"}, 32'(result), 32'd0);
        check({tag, " err"},    32'(err),    32'd0);
        check({tag, " sub_a"},  32'(sub_a),  32'd0);
        check({tag, " sub_b"},  32'(sub_b),  32'd0);
    endtask

    // One computation on the depth-8 DUT. cyc counts edges after the accepting edge.
    task automatic run_op(input logic [2:0] nv, input int glitch_at, input int rst_at,
                          input int noise_until, output int lat_o, output int ndone_o,
                          output int busy_cnt);
        lat_o = -1;
        ndone_o = 0;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b1;
        n = nv;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc <= 100; cyc++) begin
            start = (cyc == glitch_at) || (cyc <= noise_until && $urandom_range(0, 3) == 0);
            n = 3'($urandom_range(0, 7));
            if (cyc == rst_at) rst = 1'b1;
            @(posedge clk);
            @(negedge clk);
            if (cyc == rst_at) begin
                check_all_zero("midrun rst");
                rst = 1'b0;
                start = 1'b0;
                break;
            end
            if (cyc <= 3) begin
                sa_log[cyc] = sub_a;
                sb_log[cyc] = sub_b;
            end
            if (busy) busy_cnt++;
            if (done) begin
                ndone_o++;
                if (lat_o < 0) lat_o = cyc;
            end
        end
        start = 1'b0;
    endtask

    initial begin
        tbl[0] = '{3'd0, 0, 2};
        tbl[1] = '{3'd1, 1, 2};
        tbl[2] = '{3'd2, 1, 6};
        tbl[3] = '{3'd3, 2, 10};
        tbl[4] = '{3'd4, 3, 18};
        tbl[5] = '{3'd5, 5, 30};
        tbl[6] = '{3'd6, 8, 50};
        tbl[7] = '{3'd7, 13, 82};

        rst = 1'b1;
        start = 1'b0;
        n = '0;
        start2 = 1'b0;
        n2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_all_zero("reset");
        check("reset busy2", 32'(busy2), 32'd0);
        rst = 1'b0;

        // Directed table: every operand value.
        for (int i = 0; i < 8; i++) begin
            run_op(tbl[i].n, 0, 0, 0, lat, ndone, bcnt);
            check($sformatf("tbl n=%0d result", tbl[i].n), 32'(result), 32'(tbl[i].exp_res));
            check($sformatf("tbl n=%0d latency", tbl[i].n), 32'(lat), 32'(tbl[i].exp_lat));
            check($sformatf("tbl n=%0d done pulses", tbl[i].n), 32'(ndone), 32'd1);
            check($sformatf("tbl n=%0d busy cycles", tbl[i].n), 32'(bcnt), 32'(tbl[i].exp_lat));
            check($sformatf("tbl n=%0d err", tbl[i].n), 32'(err), 32'd0);
            if (tbl[i].n == 3'd2) begin
                check("n=2 dec1 sub_a", 32'(sa_log[1]), 32'd2);
                check("n=2 dec1 sub_b", 32'(sb_log[1]), 32'd1);
                check("n=2 dec2 sub_a", 32'(sa_log[2]), 32'd2);
                check("n=2 dec2 sub_b", 32'(sb_log[2]), 32'd2);
                check("n=2 pop sub_a",  32'(sa_log[3]), 32'd0);
            end
        end

        // Start pulsed mid-run is ignored.
        run_op(3'd7, 10, 0, 0, lat, ndone, bcnt);
        check("glitch result", 32'(result), 32'd13);
        check("glitch done pulses", 32'(ndone), 32'd1);
        check("glitch latency", 32'(lat), 32'd82);

        // Reset mid-run, then a fresh computation.
        run_op(3'd7, 0, 20, 0, lat, ndone, bcnt);
        check("rst run no done", 32'(ndone), 32'd0);
        run_op(3'd3, 0, 0, 0, lat, ndone, bcnt);
        check("after rst result", 32'(result), 32'd2);
        check("after rst latency", 32'(lat), 32'd10);

        // Shallow stack: n=5 overflows, n=2 fits.
        @(negedge clk);
        start2 = 1'b1;
        n2 = 3'd5;
        @(negedge clk);
        start2 = 1'b0;
        ndone = 0;
        for (int c = 0; c < 150; c++) begin
            @(negedge clk);
            if (done2) ndone++;
        end
        check("depth2 n=5 done pulses", 32'(ndone), 32'd1);
        check("depth2 n=5 err", 32'(err2), 32'(max_depth_ref(5) > 2));
        check("depth2 n=5 busy after", 32'(busy2), 32'd0);
        repeat (5) @(negedge clk);
        check("depth2 err sticky", 32'(err2), 32'd1);
        start2 = 1'b1;
        n2 = 3'd2;
        @(negedge clk);
        start2 = 1'b0;
        check("depth2 err cleared", 32'(err2), 32'd0);
        lat = -1;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (done2 && lat < 0) lat = c;
        end
        check("depth2 n=2 latency", 32'(lat), 32'd6);
        check("depth2 n=2 result", 32'(result2), 32'd1);
        check("depth2 n=2 err", 32'(err2), 32'(max_depth_ref(2) > 2));

        // Randomised operands with random start noise while busy.
        for (int r = 0; r < 20; r++) begin
            automatic logic [2:0] nv = 3'($urandom_range(0, 7));
            run_op(nv, 0, 0, lat_ref(nv), lat, ndone, bcnt);
            check($sformatf("rand%0d n=%0d result", r, nv), 32'(result), 32'(fib_ref(nv) % 256));
            check($sformatf("rand%0d n=%0d latency", r, nv), 32'(lat), 32'(lat_ref(nv)));
            check($sformatf("rand%0d n=%0d done pulses", r, nv), 32'(ndone), 32'd1);
            check($sformatf("rand%0d n=%0d err", r, nv), 32'(err), 32'(max_depth_ref(nv) > 8));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
